fact_bus_master: RTL

FACT_BUS_MASTER -- requirements
Module: fact_bus_master

---
 rtl/fact_bus_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fact_bus_master.sv
// Bus initiator that drives the memory-mapped factorial peripheral through one job
// and mirrors a successful result onto the GPIO output register.
module fact_bus_master #(
  parameter logic [31:0] FACT_BASE = 32'h0000_0800,
  parameter logic [31:0] GPIO_BASE = 32'h0000_0900,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [31:0] ADDR_N      = FACT_BASE + 32'h0;
  localparam logic [31:0] ADDR_GO     = FACT_BASE + 32'h4;
  localparam logic [31:0] ADDR_STATUS = FACT_BASE + 32'h8;
  localparam logic [31:0] ADDR_RESULT = FACT_BASE + 32'hC;
  localparam logic [31:0] ADDR_GPIO   = GPIO_BASE + 32'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_N,
    S_WR_GO,
    S_POLL,
    S_RD_RES,
    S_WR_GPIO,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic [31:0]      result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wd_q, bus_wd_d;

  // Next-state and job bookkeeping; bus outputs are precomputed from the next
  // state so the registered bus always reflects the state being occupied.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    error_d    = error_q;
    result_d   = result_q;
    bus_we_d   = 1'b0;
    bus_addr_d = 32'h0;
    bus_wd_d   = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = n;
          error_d  = 1'b0;
          result_d = 32'h0;
          state_d  = S_WR_N;
        end
      end
      S_WR_N:  state_d = S_WR_GO;
      S_WR_GO: begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        if (bus_rd[1]) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else if (bus_rd[0]) begin
          state_d = S_RD_RES;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_RES: begin
        result_d = bus_rd;
        state_d  = S_WR_GPIO;
      end
      S_WR_GPIO: state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    case (state_d)
      S_WR_N: begin
        bus_we_d   = 1'b1;
        bus_addr_d = ADDR_N;
        bus_wd_d   = {28'h0, n_d};
      end
      S_WR_GO: begin
        bus_we_d   = 1'b1;
        bus_addr_d = ADDR_GO;
        bus_wd_d   = 32'h1;
      end
      S_POLL:   bus_addr_d = ADDR_STATUS;
      S_RD_RES: bus_addr_d = ADDR_RESULT;
      S_WR_GPIO: begin
        bus_we_d   = 1'b1;
        bus_addr_d = ADDR_GPIO;
        bus_wd_d   = result_d;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= 4'h0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      result_q   <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= 32'h0;
      bus_wd_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      error_q    <= error_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_wd_q   <= bus_wd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign result   = result_q;
  assign bus_we   = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign bus_wd   = bus_wd_q;

endmodule
